morse_encoder: RTL

Transmit-side counterpart of the keypad Morse decoder. Accepts one character code per handshake, looks up its dot/dash pattern, and keys a single `tone` output (buzzer/LED) with standard unit timing. Sits between the character source (UART/keypad buffer) and the buzzer pin. Uses the same pattern display format on `led_morse`/`led_cnt` as the decoder.

---
 rtl/morse_encoder.sv | 219 +++++++++++++++++++++
 1 files changed

// File: rtl/morse_encoder.sv
`default_nettype none
// ============================================================================
//  Module   : morse_encoder
//  Purpose  : Keys a single tone output with the Morse pattern of one
//             accepted character (digits 0-9, letters A-Z) using standard
//             unit timing: dot 1 unit, dash 3, inter-symbol gap 1, trailing
//             character gap 3. The pattern being sent is shown on
//             led_morse/led_cnt (dash = 1, first symbol at bit led_cnt-1).
//  Ports    : clk, rst (async, active-high)
//             en         - enable; low aborts and holds idle
//             start      - character valid, accepted when start & ready
//             char_code  - 0x00-0x09 digits, 0x0A-0x23 letters
//             ready      - idle and enabled
//             busy       - acceptance through end of trailing gap
//             tone       - key output, 1 = mark
//             done       - one-cycle pulse on last cycle of trailing gap
//             err        - one-cycle pulse after an unsupported code
//             led_morse  - pattern, led_cnt - symbol count
//  Options  : MORSE_ENC_WORD_GAP_EN - code 0x24 sends a 7-unit word space
//  Revision : 1.0 - initial release
// ============================================================================
module morse_encoder #(
    parameter int UNIT_CYCLES = 5_000_000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       en,
    input  logic       start,
    input  logic [5:0] char_code,
    output logic       ready,
    output logic       busy,
    output logic       tone,
    output logic       done,
    output logic       err,
    output logic [4:0] led_morse,
    output logic [2:0] led_cnt
);

    localparam int              c_UW        = (UNIT_CYCLES > 1) ? $clog2(UNIT_CYCLES) : 1;
    localparam logic [c_UW-1:0] c_UNIT_LAST = c_UW'(UNIT_CYCLES - 1);
    localparam logic [c_UW-1:0] c_UNIT_PEN  = c_UW'(UNIT_CYCLES - 2);
    localparam logic [c_UW-1:0] c_UNIT_ONE  = c_UW'(1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_MARK  = 2'd1,
        S_SPACE = 2'd2,
        S_CGAP  = 2'd3
    } state_t;

    state_t          r_state;
    logic [c_UW-1:0] r_unit;
    logic [2:0]      r_sym;
    logic [2:0]      r_idx;
    logic [4:0]      r_led_morse;
    logic [2:0]      r_led_cnt;
    logic            r_done;
    logic            r_err;

    logic [7:0]      w_entry;
    logic            w_word;
    logic [4:0]      w_pat;
    logic [2:0]      w_len;
    logic            w_valid;
    logic [2:0]      w_dur;
    logic [2:0]      w_cgap;
    logic            w_sym_last;
    logic            w_unit_end;
    logic            w_state_end;

    // Pattern lookup: {pattern[4:0], length[2:0]}; length 0 marks an invalid code.
    always_comb begin
        w_entry = 8'h00;
        w_word  = 1'b0;
        case (char_code)
            6'h00: w_entry = {5'b11111, 3'd5};
            6'h01: w_entry = {5'b01111, 3'd5};
            6'h02: w_entry = {5'b00111, 3'd5};
            6'h03: w_entry = {5'b00011, 3'd5};
            6'h04: w_entry = {5'b00001, 3'd5};
            6'h05: w_entry = {5'b00000, 3'd5};
            6'h06: w_entry = {5'b10000, 3'd5};
            6'h07: w_entry = {5'b11000, 3'd5};
            6'h08: w_entry = {5'b11100, 3'd5};
            6'h09: w_entry = {5'b11110, 3'd5};
            6'h0A: w_entry = {5'b00001, 3'd2}; // A .-
            6'h0B: w_entry = {5'b01000, 3'd4}; // B -...
            6'h0C: w_entry = {5'b01010, 3'd4}; // C -.-.
            6'h0D: w_entry = {5'b00100, 3'd3}; // D -..
            6'h0E: w_entry = {5'b00000, 3'd1}; // E .
            6'h0F: w_entry = {5'b00010, 3'd4}; // F ..-.
            6'h10: w_entry = {5'b00110, 3'd3}; // G --.
            6'h11: w_entry = {5'b00000, 3'd4}; // H ....
            6'h12: w_entry = {5'b00000, 3'd2}; // I ..
            6'h13: w_entry = {5'b00111, 3'd4}; // J .---
            6'h14: w_entry = {5'b00101, 3'd3}; // K -.-
            6'h15: w_entry = {5'b00100, 3'd4}; // L .-..
            6'h16: w_entry = {5'b00011, 3'd2}; // M --
            6'h17: w_entry = {5'b00010, 3'd2}; // N -.
            6'h18: w_entry = {5'b00111, 3'd3}; // O ---
            6'h19: w_entry = {5'b00110, 3'd4}; // P .--.
            6'h1A: w_entry = {5'b01101, 3'd4}; // Q --.-
            6'h1B: w_entry = {5'b00010, 3'd3}; // R .-.
            6'h1C: w_entry = {5'b00000, 3'd3}; // S ...
            6'h1D: w_entry = {5'b00001, 3'd1}; // T -
            6'h1E: w_entry = {5'b00001, 3'd3}; // U ..-
            6'h1F: w_entry = {5'b00001, 3'd4}; // V ...-
            6'h20: w_entry = {5'b00011, 3'd3}; // W .--
            6'h21: w_entry = {5'b01001, 3'd4}; // X -..-
            6'h22: w_entry = {5'b01011, 3'd4}; // Y -.--
            6'h23: w_entry = {5'b01100, 3'd4}; // Z --..
`ifdef MORSE_ENC_WORD_GAP_EN
            6'h24: w_word  = 1'b1;
`endif
            default: w_entry = 8'h00;
        endcase
    end

    assign w_pat   = w_entry[7:3];
    assign w_len   = w_entry[2:0];
    assign w_valid = (w_len != 3'd0) | w_word;

    // A word space is the only thing that reaches CGAP with an empty pattern.
`ifdef MORSE_ENC_WORD_GAP_EN
    assign w_cgap = (r_led_cnt == 3'd0) ? 3'd7 : 3'd3;
`else
    assign w_cgap = 3'd3;
`endif

    // Length of the current state in units.
    always_comb begin
        w_dur = 3'd1;
        case (r_state)
            S_MARK:  w_dur = r_led_morse[r_idx] ? 3'd3 : 3'd1;
            S_CGAP:  w_dur = w_cgap;
            default: w_dur = 3'd1;
        endcase
    end

    assign w_sym_last  = (r_sym == (w_dur - 3'd1));
    assign w_unit_end  = (r_unit == c_UNIT_LAST);
    assign w_state_end = w_unit_end & w_sym_last;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= S_IDLE;
            r_unit      <= '0;
            r_sym       <= 3'd0;
            r_idx       <= 3'd0;
            r_led_morse <= 5'd0;
            r_led_cnt   <= 3'd0;
            r_done      <= 1'b0;
            r_err       <= 1'b0;
        end else if (!en) begin
            r_state     <= S_IDLE;
            r_unit      <= '0;
            r_sym       <= 3'd0;
            r_idx       <= 3'd0;
            r_led_morse <= 5'd0;
            r_led_cnt   <= 3'd0;
            r_done      <= 1'b0;
            r_err       <= 1'b0;
        end else begin
            r_done <= 1'b0;
            r_err  <= 1'b0;
            if (r_state == S_IDLE) begin
                r_unit <= '0;
                r_sym  <= 3'd0;
                if (start) begin
                    if (w_valid) begin
                        r_led_morse <= w_pat;
                        r_led_cnt   <= w_len;
                        r_idx       <= w_len - 3'd1;
                        r_state     <= w_word ? S_CGAP : S_MARK;
                    end else begin
                        r_err <= 1'b1;
                    end
                end
            end else begin
                // done is registered, so it is raised one cycle early to
                // land on the final cycle of the gap.
                if (r_state == S_CGAP && r_unit == c_UNIT_PEN && w_sym_last)
                    r_done <= 1'b1;

                if (w_state_end) begin
                    r_unit <= '0;
                    r_sym  <= 3'd0;
                    case (r_state)
                        S_MARK: begin
                            if (r_idx == 3'd0) begin
                                r_state <= S_CGAP;
                            end else begin
                                r_state <= S_SPACE;
                                r_idx   <= r_idx - 3'd1;
                            end
                        end
                        S_SPACE: r_state <= S_MARK;
                        default: r_state <= S_IDLE;
                    endcase
                end else if (w_unit_end) begin
                    r_unit <= '0;
                    r_sym  <= r_sym + 3'd1;
                end else begin
                    r_unit <= r_unit + c_UNIT_ONE;
                end
            end
        end
    end

    assign ready     = en & (r_state == S_IDLE);
    assign busy      = (r_state != S_IDLE);
    assign tone      = (r_state == S_MARK);
    assign done      = r_done;
    assign err       = r_err;
    assign led_morse = r_led_morse;
    assign led_cnt   = r_led_cnt;

endmodule
`default_nettype wire
